// File: rtl/if_pkg.sv
// Package: if_pkg
// Shared types and constants for the instruction-fetch stage.
//   NOP_INST          canonical NOP (addi x0,x0,0) shown to ID when no entry is valid
//   DEFAULT_RESET_PC  default PC loaded on reset
//   fq_entry_t        one fetch-queue entry: {pc, inst}
package if_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Module: fetch_queue
// Small FIFO of fq_entry_t between the I-cache response and the ID stage.
// Ports:
//   clk, rst        clock, synchronous active-high reset (control state only)
//   clear           synchronous flush: pointers and count return to zero
//   push, push_data write one entry (ignored when full)
//   pop             retire the head entry (ignored when empty)
//   head            entry at the read pointer (meaningful only when ~empty)
//   full, empty     occupancy flags
//   count           number of valid entries, 0..DEPTH
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module fetch_queue
  import if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  fq_entry_t        push_data,
  output fq_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fq_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == FULL_CNT);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Module: if_fetch_stage
// Instruction-fetch stage: holds the architectural PC, requests instructions
// from the I-cache core port and buffers {pc, inst} pairs for the ID stage.
// A redirect (flush) empties the queue and discards any fetch still in flight.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   new_pc         next PC from the next-PC adder (redirect target when flush)
//   flush          redirect from branch/jump/trap
//   id_stall       ID cannot take an instruction this cycle
//   I_core_wait    I-cache busy, im_rdata invalid
//   im_rdata       I-cache read data
//   im_req/im_addr fetch request and address (= pc)
//   pc             current PC back to the next-PC adder
//   fq_full        queue full; the next-PC adder must hold
//   if_valid/if_pc/if_inst  ID-side entry (if_inst = NOP, if_pc = 0 when invalid)
// Optional build macro IF_PERF_CNT_EN adds perf_fetch_cnt, perf_wait_cnt and
// perf_drop_cnt (32-bit, wrapping) without changing any other behaviour.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] new_pc,
  input  logic        flush,
  input  logic        id_stall,
  input  logic        I_core_wait,
  input  logic [31:0] im_rdata,
  output logic        im_req,
  output logic [31:0] im_addr,
  output logic [31:0] pc,
  output logic        fq_full,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  logic             rst_q;
  logic             drop;
  logic             complete;
  logic             push;
  logic             pop;
  logic             fq_empty;
  logic [CNT_W-1:0] fq_count;
  fq_entry_t        fq_in;
  fq_entry_t        fq_head;

  // Requests start one cycle after reset releases.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign im_req   = ~rst_q & ~fq_full;
  assign im_addr  = pc;
  assign complete = im_req & ~I_core_wait;
  assign push     = complete & ~drop & ~flush;
  assign pop      = if_valid & ~id_stall;
  assign fq_in    = '{pc: pc, inst: im_rdata};

  // A discarded (stale) completion must not advance the PC: it already
  // holds the redirect target.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (flush) begin
      pc <= new_pc;
    end else if (complete && !drop) begin
      pc <= new_pc;
    end
  end

  // drop marks a fetch that was in flight when a redirect arrived; the next
  // completion belongs to the old path and is thrown away.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop <= 1'b0;
    end else if (flush && (drop || (im_req && I_core_wait))) begin
      drop <= 1'b1;
    end else if (complete) begin
      drop <= 1'b0;
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fq (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .pop       (pop),
    .push_data (fq_in),
    .head      (fq_head),
    .full      (fq_full),
    .empty     (fq_empty),
    .count     (fq_count)
  );

  assign if_valid = ~fq_empty;
  assign if_pc    = if_valid ? fq_head.pc   : 32'h0;
  assign if_inst  = if_valid ? fq_head.inst : NOP_INST;

`ifdef IF_PERF_CNT_EN
  // Drops count both stale/redirected completions and entries thrown away
  // by a flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (im_req && I_core_wait) perf_wait_cnt <= perf_wait_cnt + 32'd1;
      perf_drop_cnt <= perf_drop_cnt
                     + 32'(complete & (drop | flush))
                     + (flush ? 32'(fq_count) : 32'd0);
    end
  end
`else
  // Occupancy count only feeds the performance counters.
  logic fq_count_unused;
  assign fq_count_unused = ^fq_count;
`endif

endmodule
